rom_seq_reader: RTL and testbench

Sequential read engine for the 8-entry, 4-bit lookup ROM. On a start command it walks a burst of consecutive ROM addresses, wrapping past the top of the ROM, and delivers each word downstream on a valid/ready stream. It drives the ROM address port and consumes the ROM's combinational data output. It sits between the control logic that issues burst commands and any consumer of ROM contents.

---
 rtl/rom_pkg.sv | 14 +
 rtl/rom_seq_reader.sv | 98 +++++++++
 tb/tb_rom_seq_reader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rom_pkg.sv
// Shared ROM geometry and the read-engine FSM state encoding.
package rom_pkg;

    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 4;
    localparam int ROM_DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rom_seq_reader.sv
// Burst read engine: walks consecutive ROM addresses (wrapping) and streams each word
// on a valid/ready port. Handshake: a beat transfers on a rising edge where o_vld & i_rdy.
module rom_seq_reader
    import rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W,
    parameter int LEN_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_dat,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_state
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    rd_state_t        state;
    rd_state_t        state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_eff;
    logic             hshk;

    // Requests longer than the ROM are clamped so no address is read twice.
    assign len_eff = (i_len > MAX_LEN) ? MAX_LEN : i_len;
    assign hshk    = o_vld & i_rdy;
    assign o_busy  = (state != IDLE);
    assign o_state = state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start && (len_eff != '0)) state_nxt = FETCH;
            FETCH:   state_nxt = HOLD;
            HOLD:    if (hshk) state_nxt = o_last ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rom_addr <= '0;
            o_dat      <= '0;
            o_vld      <= 1'b0;
            o_last     <= 1'b0;
            o_done     <= 1'b0;
            cnt        <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (len_eff == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            o_rom_addr <= i_base;
                            cnt        <= len_eff;
                        end
                    end
                end
                FETCH: begin
                    o_dat  <= i_rom_dat;
                    o_vld  <= 1'b1;
                    o_last <= (cnt == LEN_W'(1));
                end
                HOLD: begin
                    // Address advances only here, giving the ROM a full cycle before the next capture.
                    if (hshk) begin
                        cnt        <= cnt - LEN_W'(1);
                        o_rom_addr <= o_rom_addr + ADDR_W'(1);
                        o_vld      <= 1'b0;
                        if (o_last) begin
                            o_done <= 1'b1;
                            o_last <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed and randomized bursts against a queue-based model of the ROM walk.
module tb_rom_seq_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] base;
    logic [3:0] len;
    logic [2:0] rom_addr;
    logic [3:0] rom_dat;
    logic [3:0] dat;
    logic       vld;
    logic       rdy;
    logic       last;
    logic       busy;
    logic       done;
    logic [1:0] state;

    logic [3:0] rom [8];
    logic [7:0] exp_q[$];   // {addr[2:0], last, data[3:0]} per expected beat

    int n_vec = 0;
    int n_err = 0;

    assign rom_dat = rom[rom_addr];

    rom_seq_reader dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_base     (base),
        .i_len      (len),
        .o_rom_addr (rom_addr),
        .i_rom_dat  (rom_dat),
        .o_dat      (dat),
        .o_vld      (vld),
        .i_rdy      (rdy),
        .o_last     (last),
        .o_busy     (busy),
        .o_done     (done),
        .o_state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_dat"},  32'(dat),      32'd0);
        check({tag, "_vld"},  32'(vld),      32'd0);
        check({tag, "_last"}, 32'(last),     32'd0);
        check({tag, "_busy"}, 32'(busy),     32'd0);
        check({tag, "_done"}, 32'(done),     32'd0);
        check({tag, "_st"},   32'(state),    32'd0);
    endtask

    // Runs one burst from the current cycle; returns in the cycle after completion.
    task automatic run_burst(input logic [2:0] b, input logic [3:0] l, input int stall_beat,
                             input int stall_n, input bit rand_stall, input bit poke,
                             input int rst_beat);
        int         eff;
        int         stalls;
        int         a;
        logic [7:0] e;
        eff = (l > 4'd8) ? 8 : int'(l);
        for (int k = 0; k < eff; k++) begin
            a = (int'(b) + k) % 8;
            exp_q.push_back({3'(a), (k == eff - 1), rom[a]});
        end
        base  = b;
        len   = l;
        start = 1'b1;
        rdy   = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        base  = 3'($urandom_range(0, 7));
        len   = 4'($urandom_range(0, 15));
        if (eff == 0) begin
            check("len0_done", 32'(done), 32'd1);
            check("len0_busy", 32'(busy), 32'd0);
            check("len0_vld",  32'(vld),  32'd0);
            step();
            check("len0_done_pulse", 32'(done), 32'd0);
            check("len0_vld2", 32'(vld), 32'd0);
            return;
        end
        check("start_busy", 32'(busy), 32'd1);
        check("start_vld",  32'(vld),  32'd0);
        step();
        for (int k = 0; k < eff; k++) begin
            e = exp_q.pop_front();
            check("beat_vld",  32'(vld),      32'd1);
            check("beat_dat",  32'(dat),      32'(e[3:0]));
            check("beat_last", 32'(last),     32'(e[4]));
            check("beat_addr", 32'(rom_addr), 32'(e[7:5]));
            if (k == stall_beat) stalls = stall_n;
            else if (rand_stall) stalls = $urandom_range(0, 2);
            else stalls = 0;
            if (poke && k == 0) begin
                start = 1'b1;
                base  = 3'($urandom_range(0, 7));
                len   = 4'($urandom_range(1, 15));
            end
            for (int s = 0; s < stalls; s++) begin
                rdy = 1'b0;
                step();
                start = 1'b0;
                check("stall_vld",  32'(vld),      32'd1);
                check("stall_dat",  32'(dat),      32'(e[3:0]));
                check("stall_last", 32'(last),     32'(e[4]));
                check("stall_addr", 32'(rom_addr), 32'(e[7:5]));
            end
            if (k == rst_beat) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                start = 1'b0;
                check_idle_zero("reset_mid");
                step();
                check("reset_no_done", 32'(done), 32'd0);
                check("reset_no_busy", 32'(busy), 32'd0);
                exp_q.delete();
                rdy = 1'b0;
                return;
            end
            rdy = 1'b1;
            step();
            start = 1'b0;
            check("hshk_vld_drop", 32'(vld), 32'd0);
            if (k == eff - 1) begin
                check("done_pulse", 32'(done), 32'd1);
                check("done_busy",  32'(busy), 32'd0);
                check("done_last",  32'(last), 32'd0);
            end else begin
                check("mid_done", 32'(done), 32'd0);
                check("mid_busy", 32'(busy), 32'd1);
                rdy = 1'($urandom_range(0, 1));
                step();
            end
        end
        rdy = 1'b0;
    endtask

    task automatic settle_idle(input string tag);
        step();
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_vld"},  32'(vld),  32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rom[0] = 4'h9; rom[1] = 4'hB; rom[2] = 4'h2; rom[3] = 4'h3;
        rom[4] = 4'hE; rom[5] = 4'h0; rom[6] = 4'h0; rom[7] = 4'h0;
        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        len   = '0;
        rdy   = 1'b0;
        step();
        step();
        check_idle_zero("reset");
        rst_n = 1'b1;
        step();

        run_burst(3'd0, 4'd5, -1, 0, 1'b0, 1'b0, -1);
        run_burst(3'd6, 4'd4, -1, 0, 1'b0, 1'b0, -1);   // starts in the done cycle
        settle_idle("after_wrap");
        run_burst(3'd0, 4'd3, 1, 3, 1'b0, 1'b0, -1);
        settle_idle("after_stall");
        run_burst(3'd2, 4'd0, -1, 0, 1'b0, 1'b0, -1);
        run_burst(3'd4, 4'd12, -1, 0, 1'b0, 1'b0, -1);
        settle_idle("after_clamp");
        run_burst(3'd1, 4'd3, -1, 0, 1'b0, 1'b1, -1);
        settle_idle("after_poke");
        run_burst(3'd0, 4'd4, 1, 2, 1'b0, 1'b0, 1);
        run_burst(3'd3, 4'd2, -1, 0, 1'b0, 1'b0, -1);
        settle_idle("after_reset");

        for (int i = 0; i < 8; i++) rom[i] = 4'($urandom_range(0, 15));
        for (int t = 0; t < 30; t++) begin
            run_burst(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), -1, 0,
                      1'b1, 1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 1) == 1) settle_idle("rand_gap");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
